// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit. It handles one op at a time and
//   resolves one bit per cycle. Multiplies use shift-add on sign-stripped
//   magnitudes. Divides use restoring division on magnitudes. The result sign
//   is fixed up on the last CALC edge. Divide-by-zero and signed overflow skip
//   CALC and go straight to DONE with a constant result.
//
// Ports
//   clk, reset                     core clock, async active-high reset
//   in_valid/in_ready              op handshake (ready only in IDLE)
//   in_funct3                      RV32M funct3 (MUL..REMU)
//   in_rs1_data/in_rs2_data/in_rd  operands and destination index
//   flush                          kill in-flight op, return to IDLE
//   wb_valid/wb_ready              result handshake toward writeback
//   wb_rd/wb_data                  destination index and result
//   busy                           unit not IDLE
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Latched op context
    typedef struct packed {
        logic [2:0] funct3;
        logic       neg_a;   // operand A was negative (magnitude stored)
        logic       neg_b;   // operand B was negative (magnitude stored)
    } op_ctx_t;

    state_t          state, state_nxt;
    op_ctx_t         ctx;
    logic [CW-1:0]   cnt;
    // Mul: {acc_hi,acc_lo} is the product register, acc_lo starts as the
    // multiplier and opb holds the multiplicand.
    // Div: acc_lo holds the dividend and shifts quotient bits in, acc_hi is
    // the partial remainder, and opb is the divisor.
    logic [XLEN-1:0] acc_hi, acc_lo, opb;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            accept, retire, last;
    logic            in_is_div, in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res, abs_a, abs_b;

    assign accept = (state == IDLE) && in_valid && !flush;
    assign retire = wb_valid && wb_ready;
    assign last   = (cnt == CW'(XLEN-1));

    always_comb begin
        in_is_div = in_funct3[2];
        // MUL (000) is treated as unsigned because the low half is identical
        if (in_is_div) begin
            in_sgn_a = !in_funct3[0];
            in_sgn_b = !in_funct3[0];
        end else begin
            in_sgn_a = (in_funct3[1:0] == 2'b01) || (in_funct3[1:0] == 2'b10);
            in_sgn_b = (in_funct3[1:0] == 2'b01);
        end
        in_neg_a = in_sgn_a && in_rs1_data[XLEN-1];
        in_neg_b = in_sgn_b && in_rs2_data[XLEN-1];
        abs_a    = in_neg_a ? -in_rs1_data : in_rs1_data;
        abs_b    = in_neg_b ? -in_rs2_data : in_rs2_data;

        div_zero = in_is_div && (in_rs2_data == '0);
        div_ovf  = in_is_div && !in_funct3[0] &&
                   (in_rs1_data == SMIN) && (in_rs2_data == '1);
        special  = div_zero || div_ovf;
        // funct3[1] selects REM* over DIV*
        if (div_zero) special_res = in_funct3[1] ? in_rs1_data : '1;
        else          special_res = in_funct3[1] ? '0 : SMIN;
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (ctx.funct3[2]) begin
            // Restoring division: keep the difference when it does not borrow
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end

        // Sign correction, applied to the value the last step produces
        prod   = {step_hi, step_lo};
        prod_s = (ctx.neg_a ^ ctx.neg_b) ? -prod : prod;
        quo_s  = (ctx.neg_a ^ ctx.neg_b) ? -step_lo : step_lo;
        rem_s  = ctx.neg_a ? -step_hi : step_hi;   // remainder follows dividend
        if (ctx.funct3[2])               final_res = ctx.funct3[1] ? rem_s : quo_s;
        else if (ctx.funct3[1:0] == 2'b00) final_res = prod_s[XLEN-1:0];
        else                             final_res = prod_s[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (last)   state_nxt = DONE;
            DONE:    if (retire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctx      <= '0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (flush) begin
            cnt      <= '0;
            wb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctx.funct3 <= in_funct3;
                        ctx.neg_a  <= in_neg_a;
                        ctx.neg_b  <= in_neg_b;
                        cnt        <= '0;
                        wb_rd      <= in_rd;
                        acc_hi     <= '0;
                        if (in_is_div) begin
                            acc_lo <= abs_a;
                            opb    <= abs_b;
                        end else begin
                            acc_lo <= abs_b;
                            opb    <= abs_a;
                        end
                        if (special) wb_data <= special_res;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (last) wb_data <= final_res;
                end
                DONE: begin
                    // wb_valid rises one edge after entering DONE
                    if (!wb_valid)     wb_valid <= 1'b1;
                    else if (wb_ready) wb_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed bench for muldiv_unit. It uses hand-computed vectors and checks
//   each point with an immediate assertion. Inputs change and outputs are
//   sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd(in_rd),
        .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one op, wait for the result within a bounded window, then check
    // latency, data and rd, and finally retire the result.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        int k;
        in_valid = 1'b1; in_funct3 = f; in_rs1_data = a; in_rs2_data = b; in_rd = rd;
        tick();                                   // accept edge E
        in_valid = 1'b0; in_rs1_data = $urandom; in_rs2_data = $urandom; in_rd = 5'd31;
        k = 0;
        do begin tick(); k++; end while (!wb_valid && k < lat + 5);
        chk({tag, " latency"}, k, lat);
        chk({tag, " data"}, wb_data, exp);
        chk({tag, " rd"}, wb_rd, rd);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({tag, " retired"}, {wb_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int  k;
        logic seen;

        // Reset state
        #1;
        chk("rst wb_valid", wb_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst wb_rd", wb_rd, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Multiplies
        do_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        do_op("MULH",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 33);
        do_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 33);
        do_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
        do_op("MULH2",  3'b001, 32'h8000_0000, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, 33);

        // Divides
        do_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6,  32'hFFFF_FFFD, 33);
        do_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7,  32'hFFFF_FFFF, 33);
        do_op("DIVU",   3'b101, 32'd100,       32'd7, 5'd8,  32'd14,        33);
        do_op("REMU",   3'b111, 32'd100,       32'd7, 5'd9,  32'd2,         33);
        do_op("DIVrd0", 3'b100, 32'd50,        32'hFFFF_FFFB, 5'd0, 32'hFFFF_FFF6, 33);

        // Special cases
        do_op("DIVU/0", 3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        do_op("REM/0",  3'b110, 32'd5,         32'd0,         5'd11, 32'd5,         1);
        do_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        do_op("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1);

        // Backpressure: hold the result in DONE and ignore in_valid outside IDLE
        in_valid = 1'b1; in_funct3 = 3'b111; in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd = 5'd9;
        tick();
        in_funct3 = 3'b000; in_rs1_data = 32'd3; in_rs2_data = 32'd3; in_rd = 5'd20;
        k = 0;
        do begin tick(); k++; end while (!wb_valid && k < 40);
        chk("hold latency", k, 33);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold valid/ready", {wb_valid, in_ready}, 2'b10);
            chk("hold data", wb_data, 32'd2);
            chk("hold rd", wb_rd, 5'd9);
        end
        wb_ready = 1'b1;                          // in_valid still high on retire
        tick();
        wb_ready = 1'b0; in_valid = 1'b0;
        chk("retire no accept", {wb_valid, busy, in_ready}, 3'b001);

        // wb_ready with nothing valid, and flush beating in_valid in IDLE
        wb_ready = 1'b1; in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b101;
        in_rs1_data = 32'd9; in_rs2_data = 32'd0;
        tick();
        flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
        tick();
        chk("flush beats in_valid", {busy, wb_valid}, 2'b00);

        // Flush at counter 10
        in_valid = 1'b1; in_funct3 = 3'b101; in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd = 5'd14;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("pre-flush busy", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("post-flush state", {busy, in_ready, wb_valid}, 3'b010);
        seen = 1'b0;
        repeat (40) begin tick(); if (wb_valid) seen = 1'b1; end
        chk("flush no result", seen, 0);

        // Async reset during CALC
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1_data = 32'd7; in_rs2_data = 32'd9; in_rd = 5'd17;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("async rst state", {busy, in_ready, wb_valid}, 3'b010);
        chk("async rst data", wb_data, 0);
        chk("async rst rd", wb_rd, 0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin tick(); if (wb_valid || busy) seen = 1'b1; end
        chk("reset no result", seen, 0);

        // Still functional afterwards
        do_op("post-rst MULHU", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'h0000_0001, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
